// File: rtl/bc_axi_pkg.sv
// Shared types and constants for the bus_controller-to-AXI4 master bridge.
package bc_axi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_AR,
      ST_R,
      ST_AW,
      ST_W,
      ST_B,
      ST_DONE
   } state_t;

   localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
   localparam logic [2:0] AXI_SIZE_4B       = 3'b010;
   localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
   localparam logic [7:0] LINE_LEN          = 8'd3;
   localparam logic [3:0] PERIPH_HI_DEFAULT = 4'h1;

   // Write payload and access width captured when the request is accepted.
   typedef struct packed {
      logic         single;
      logic [127:0] data;
   } bc_req_t;

   // Peripheral accesses are word aligned; cache accesses are line aligned.
   function automatic logic [31:0] align_addr(input logic [31:0] addr, input logic single);
      return single ? {addr[31:2], 2'b00} : {addr[31:4], 4'b0000};
   endfunction

endpackage

// File: rtl/bc_axi_master_if.sv
// AXI4 read/write channel bundle between the bridge (master) and the interconnect (slave).
interface bc_axi_master_if;

   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        awvalid;
   logic        awready;

   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;

   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;

   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   modport master (
      output awaddr, awlen, awsize, awburst, awvalid, input awready,
      output wdata, wstrb, wlast, wvalid, input wready,
      input  bresp, bvalid, output bready,
      output araddr, arlen, arsize, arburst, arvalid, input arready,
      input  rdata, rresp, rlast, rvalid, output rready
   );

   modport slave (
      input  awaddr, awlen, awsize, awburst, awvalid, output awready,
      input  wdata, wstrb, wlast, wvalid, output wready,
      output bresp, bvalid, input bready,
      input  araddr, arlen, arsize, arburst, arvalid, output arready,
      output rdata, rresp, rlast, rvalid, input rready
   );

endinterface

// File: rtl/bc_axi_master.sv
// Runs one bus_controller request at a time as an AXI4 transaction: 4-beat INCR
// bursts for cache lines, single beats for the peripheral region.
module bc_axi_master
   import bc_axi_pkg::*;
#(
   parameter logic [3:0] PERIPH_HI  = PERIPH_HI_DEFAULT,
   parameter int         LINE_BEATS = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          bc_valid_req_i,
   input  logic          bc_rw_i,
   input  logic [31:0]   bc_addr_i,
   input  logic [127:0]  bc_data_i,
   output logic [127:0]  axi_data_o,
   output logic          axi_rd_over_o,
   output logic          axi_wr_over_o,
   output logic          axi_err_o,
   bc_axi_master_if.master m
);

   localparam logic [1:0] LAST_BEAT = 2'(LINE_BEATS - 1);

   state_t     state;
   bc_req_t    req;
   logic [1:0] beat;
   logic       err;
   logic       req_single;
   logic [1:0] next_beat;
   logic       resp_bad;

   assign req_single = (bc_addr_i[31:28] == PERIPH_HI);
   assign next_beat  = beat + 2'd1;
   assign resp_bad   = (state == ST_R) ? (m.rresp != AXI_RESP_OKAY)
                                       : (m.bresp != AXI_RESP_OKAY);

   // NOTE: every register here is state, so all assignments are non-blocking;
   // blocking ones would let later statements see this cycle's new values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the read line buffer is ordinary flops, not a RAM, so it is
         // reset along with everything else and reads back zero after reset.
         state         <= ST_IDLE;
         req           <= '0;
         beat          <= '0;
         err           <= 1'b0;
         axi_data_o    <= '0;
         axi_rd_over_o <= 1'b0;
         axi_wr_over_o <= 1'b0;
         axi_err_o     <= 1'b0;
         m.awaddr      <= '0;
         m.awlen       <= '0;
         m.awsize      <= '0;
         m.awburst     <= '0;
         m.awvalid     <= 1'b0;
         m.wdata       <= '0;
         m.wstrb       <= '0;
         m.wlast       <= 1'b0;
         m.wvalid      <= 1'b0;
         m.bready      <= 1'b0;
         m.araddr      <= '0;
         m.arlen       <= '0;
         m.arsize      <= '0;
         m.arburst     <= '0;
         m.arvalid     <= 1'b0;
         m.rready      <= 1'b0;
      end else begin
         axi_rd_over_o <= 1'b0;
         axi_wr_over_o <= 1'b0;
         axi_err_o     <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bc_valid_req_i) begin
                  req <= '{single: req_single, data: bc_data_i};
                  if (bc_rw_i) begin
                     state     <= ST_AR;
                     m.arvalid <= 1'b1;
                     m.araddr  <= align_addr(bc_addr_i, req_single);
                     m.arlen   <= req_single ? 8'd0 : LINE_LEN;
                     m.arsize  <= AXI_SIZE_4B;
                     m.arburst <= AXI_BURST_INCR;
                  end else begin
                     state     <= ST_AW;
                     m.awvalid <= 1'b1;
                     m.awaddr  <= align_addr(bc_addr_i, req_single);
                     m.awlen   <= req_single ? 8'd0 : LINE_LEN;
                     m.awsize  <= AXI_SIZE_4B;
                     m.awburst <= AXI_BURST_INCR;
                  end
               end
            end
            ST_AR: begin
               if (m.arready) begin
                  m.arvalid  <= 1'b0;
                  m.rready   <= 1'b1;
                  axi_data_o <= '0;
                  beat       <= '0;
                  state      <= ST_R;
               end
            end
            ST_R: begin
               if (m.rvalid) begin
                  axi_data_o[{beat, 5'd0} +: 32] <= m.rdata;
                  // Overlong bursts keep landing in the top word.
                  if (beat != LAST_BEAT) beat <= next_beat;
                  if (resp_bad) err <= 1'b1;
                  if (m.rlast) begin
                     m.rready      <= 1'b0;
                     axi_rd_over_o <= 1'b1;
                     axi_err_o     <= err | resp_bad;
                     state         <= ST_DONE;
                  end
               end
            end
            ST_AW: begin
               if (m.awready) begin
                  m.awvalid <= 1'b0;
                  m.wvalid  <= 1'b1;
                  m.wdata   <= req.data[31:0];
                  m.wstrb   <= 4'hF;
                  m.wlast   <= req.single;
                  beat      <= '0;
                  state     <= ST_W;
               end
            end
            ST_W: begin
               if (m.wready) begin
                  if (m.wlast) begin
                     m.wvalid <= 1'b0;
                     m.wlast  <= 1'b0;
                     m.wstrb  <= '0;
                     m.bready <= 1'b1;
                     state    <= ST_B;
                  end else begin
                     beat    <= next_beat;
                     m.wdata <= req.data[{next_beat, 5'd0} +: 32];
                     m.wlast <= (next_beat == LAST_BEAT);
                  end
               end
            end
            ST_B: begin
               if (m.bvalid) begin
                  m.bready      <= 1'b0;
                  err           <= err | resp_bad;
                  axi_wr_over_o <= 1'b1;
                  axi_err_o     <= err | resp_bad;
                  state         <= ST_DONE;
               end
            end
            ST_DONE: begin
               err   <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bc_axi_master.sv
// Randomized self-checking bench: a behavioural AXI slave plus a transaction-level
// model of expected addresses, beat data, completion timing and error reporting.
module tb_bc_axi_master;
   import bc_axi_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         bc_valid_req_i;
   logic         bc_rw_i;
   logic [31:0]  bc_addr_i;
   logic [127:0] bc_data_i;
   logic [127:0] axi_data_o;
   logic         axi_rd_over_o;
   logic         axi_wr_over_o;
   logic         axi_err_o;

   bc_axi_master_if axi();

   bc_axi_master dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .bc_valid_req_i(bc_valid_req_i),
      .bc_rw_i       (bc_rw_i),
      .bc_addr_i     (bc_addr_i),
      .bc_data_i     (bc_data_i),
      .axi_data_o    (axi_data_o),
      .axi_rd_over_o (axi_rd_over_o),
      .axi_wr_over_o (axi_wr_over_o),
      .axi_err_o     (axi_err_o),
      .m             (axi)
   );

   always #5 clk = ~clk;

   int           n_cmp = 0;
   int           n_bad = 0;
   logic [31:0]  rd_words [8];
   logic [127:0] last_rd = '0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_addr(input logic [31:0] a);
      return (a[31:28] == 4'h1) ? (a & ~32'h3) : (a & ~32'hF);
   endfunction

   task automatic quiet_slave();
      axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
      axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00;
      axi.rdata = '0;
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_data"}, axi_data_o, 128'(0));
      check({tag, "_flags"}, 128'({axi_rd_over_o, axi_wr_over_o, axi_err_o}), 128'(0));
      check({tag, "_ctrl"}, 128'({axi.awvalid, axi.wvalid, axi.wlast, axi.wstrb, axi.bready,
                                  axi.arvalid, axi.rready}), 128'(0));
      check({tag, "_addr"}, 128'({axi.awaddr, axi.araddr, axi.awlen, axi.arlen, axi.awsize,
                                  axi.arsize, axi.awburst, axi.arburst, axi.wdata}), 128'(0));
   endtask

   task automatic do_read(input logic [31:0] addr, input int nbeats, input bit zero_wait,
                          input int err_beat, input bit extra_req, input int exp_lat);
      logic [127:0] exp_data = '0;
      bit exp_err = 1'b0, ar_wait = 1'b0, extra_sent = 1'b0;
      bit single = (addr[31:28] == 4'h1);
      int cyc = 0, ar_hs = 0, ar_after = 0, beats = 0, overs = 0, over_cyc = -1, stray = 0;
      for (int i = 0; i < nbeats; i++) begin
         exp_data[32*((i < 3) ? i : 3) +: 32] = rd_words[i];
         if (i == err_beat) exp_err = 1'b1;
      end
      @(negedge clk);
      bc_valid_req_i = 1'b1; bc_rw_i = 1'b1; bc_addr_i = addr;
      bc_data_i = {$urandom, $urandom, $urandom, $urandom};
      while (cyc < 400 && !(overs > 0 && cyc >= over_cyc + 3)) begin
         @(negedge clk);
         cyc++;
         bc_valid_req_i = 1'b0;
         if (ar_wait) check("arvalid_hold", 128'(axi.arvalid), 128'(1));
         if (axi.arvalid) begin
            if (ar_hs > 0) ar_after++;
            check("araddr", 128'(axi.araddr), 128'(exp_addr(addr)));
            check("arlen", 128'(axi.arlen), single ? 128'(0) : 128'(3));
            check("ar_size_burst", 128'({axi.arsize, axi.arburst}), 128'(5'b010_01));
         end
         if (axi_rd_over_o) begin
            overs++;
            if (over_cyc < 0) begin
               over_cyc = cyc;
               check("rd_data", axi_data_o, exp_data);
               check("rd_err", 128'(axi_err_o), 128'(exp_err));
            end
         end
         if (axi_wr_over_o || (axi_err_o && !axi_rd_over_o)) stray++;
         axi.arready = zero_wait ? 1'b1 : 1'($urandom_range(0, 1));
         if (axi.arvalid && axi.arready) ar_hs++;
         ar_wait = axi.arvalid && !axi.arready;
         if (axi.rready && beats < nbeats && (zero_wait || $urandom_range(0, 2) != 0)) begin
            axi.rvalid = 1'b1;
            axi.rdata  = rd_words[beats];
            axi.rlast  = (beats == nbeats - 1);
            axi.rresp  = (beats == err_beat) ? 2'b10 : 2'b00;
            beats++;
            if (extra_req && !extra_sent) begin
               bc_valid_req_i = 1'b1; bc_rw_i = 1'b1; bc_addr_i = addr ^ 32'h0000_0100;
               extra_sent = 1'b1;
            end
         end else begin
            axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00; axi.rdata = $urandom;
         end
      end
      axi.arready = 1'b0;
      check("rd_over_count", 128'(overs), 128'(1));
      check("ar_handshakes", 128'(ar_hs), 128'(1));
      check("no_second_ar", 128'(ar_after), 128'(0));
      check("rd_beats", 128'(beats), 128'(nbeats));
      check("rd_stray_pulse", 128'(stray), 128'(0));
      if (exp_lat > 0) check("rd_latency", 128'(over_cyc), 128'(exp_lat));
      last_rd = exp_data;
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [127:0] data, input bit zero_wait,
                           input int stall_beat, input int stall_len, input bit bresp_err,
                           input int exp_lat, input int rst_at);
      bit single = (addr[31:28] == 4'h1);
      bit aw_wait = 1'b0, w_wait = 1'b0;
      int nw = single ? 1 : 4;
      int cyc = 0, aw_hs = 0, aw_after = 0, w_hs = 0, w_cyc = 0, b_hs = 0;
      int overs = 0, over_cyc = -1, stray = 0, stall_cnt = 0, quiet_bad = 0;
      @(negedge clk);
      bc_valid_req_i = 1'b1; bc_rw_i = 1'b0; bc_addr_i = addr; bc_data_i = data;
      while (cyc < 400 && !(overs > 0 && cyc >= over_cyc + 3)) begin
         @(negedge clk);
         cyc++;
         bc_valid_req_i = 1'b0;
         if (aw_wait) check("awvalid_hold", 128'(axi.awvalid), 128'(1));
         if (axi.awvalid) begin
            if (aw_hs > 0) aw_after++;
            check("awaddr", 128'(axi.awaddr), 128'(exp_addr(addr)));
            check("awlen", 128'(axi.awlen), single ? 128'(0) : 128'(3));
            check("aw_size_burst", 128'({axi.awsize, axi.awburst}), 128'(5'b010_01));
         end
         if (w_wait) check("wvalid_hold", 128'(axi.wvalid), 128'(1));
         if (axi.wvalid) begin
            w_cyc++;
            check("w_after_aw", 128'(aw_hs), 128'(1));
            check("wdata", 128'(axi.wdata), 128'(32'(data >> (32 * w_hs))));
            check("wlast", 128'(axi.wlast), 128'(w_hs == nw - 1));
            check("wstrb", 128'(axi.wstrb), 128'(4'hF));
         end
         if (axi_wr_over_o) begin
            overs++;
            if (over_cyc < 0) begin
               over_cyc = cyc;
               check("wr_err", 128'(axi_err_o), 128'(bresp_err));
               check("b_before_over", 128'(b_hs), 128'(1));
            end
         end
         if (axi_rd_over_o || (axi_err_o && !axi_wr_over_o)) stray++;
         if (rst_at >= 0 && axi.wvalid && w_hs == rst_at) begin
            rst_n = 1'b0;
            quiet_slave();
            #1;
            reset_checks("midrst");
            last_rd = '0;
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            repeat (6) begin
               @(negedge clk);
               if (axi_rd_over_o || axi_wr_over_o || axi_err_o || axi.arvalid || axi.awvalid ||
                   axi.wvalid) quiet_bad++;
            end
            check("post_rst_quiet", 128'(quiet_bad), 128'(0));
            return;
         end
         axi.awready = zero_wait ? 1'b1 : 1'($urandom_range(0, 1));
         if (axi.awvalid && axi.awready) aw_hs++;
         aw_wait = axi.awvalid && !axi.awready;
         if (axi.wvalid && w_hs == stall_beat && stall_cnt < stall_len) begin
            axi.wready = 1'b0;
            stall_cnt++;
         end else begin
            axi.wready = zero_wait ? 1'b1 : 1'($urandom_range(0, 1));
         end
         if (axi.wvalid && axi.wready) w_hs++;
         w_wait = axi.wvalid && !axi.wready;
         if (axi.bready && b_hs == 0 && (zero_wait || $urandom_range(0, 1) != 0)) begin
            axi.bvalid = 1'b1; axi.bresp = bresp_err ? 2'b10 : 2'b00;
            b_hs++;
         end else begin
            axi.bvalid = 1'b0; axi.bresp = 2'b00;
         end
      end
      axi.awready = 1'b0; axi.wready = 1'b0;
      check("wr_over_count", 128'(overs), 128'(1));
      check("aw_handshakes", 128'(aw_hs), 128'(1));
      check("no_second_aw", 128'(aw_after), 128'(0));
      check("w_beats", 128'(w_hs), 128'(nw));
      check("wr_stray_pulse", 128'(stray), 128'(0));
      check("data_hold", axi_data_o, last_rd);
      if (zero_wait) check("w_cycles", 128'(w_cyc), 128'(nw + stall_len));
      if (exp_lat > 0) check("wr_latency", 128'(over_cyc), 128'(exp_lat));
   endtask

   initial begin
      rst_n = 1'b0;
      bc_valid_req_i = 1'b0; bc_rw_i = 1'b0; bc_addr_i = '0; bc_data_i = '0;
      quiet_slave();
      repeat (3) @(negedge clk);
      reset_checks("por");
      rst_n = 1'b1;
      @(negedge clk);

      rd_words[0] = 32'h11; rd_words[1] = 32'h22; rd_words[2] = 32'h33; rd_words[3] = 32'h44;
      do_read(32'h8000_0014, 4, 1'b1, -1, 1'b0, 6);
      rd_words[0] = 32'hDEAD_BEEF;
      do_read(32'h1000_0006, 1, 1'b1, -1, 1'b0, 3);
      do_write(32'h8000_0020, {32'hD, 32'hC, 32'hB, 32'hA}, 1'b1, 1, 2, 1'b0, 0, -1);
      do_write(32'h8000_1234, {$urandom, $urandom, $urandom, $urandom}, 1'b1, -1, 0, 1'b0, 7, -1);
      do_write(32'h1000_0043, {$urandom, $urandom, $urandom, $urandom}, 1'b1, -1, 0, 1'b0, 4, -1);

      for (int i = 0; i < 8; i++) rd_words[i] = $urandom;
      do_read(32'h8000_0100, 4, 1'b1, 2, 1'b0, 6);
      do_read(32'h8000_0200, 4, 1'b1, -1, 1'b0, 6);
      do_read(32'h8000_0300, 4, 1'b1, -1, 1'b1, 6);
      do_read(32'h8000_0400, 5, 1'b0, -1, 1'b0, 0);
      do_write(32'h8000_0500, {$urandom, $urandom, $urandom, $urandom}, 1'b0, -1, 0, 1'b1, 0, -1);

      for (int n = 0; n < 24; n++) begin
         bit periph = ($urandom_range(0, 3) == 0);
         logic [31:0] a = {periph ? 4'h1 : 4'($urandom_range(2, 15)), 28'($urandom)};
         int nb = periph ? 1 : 4;
         for (int i = 0; i < 8; i++) rd_words[i] = $urandom;
         if ($urandom_range(0, 1) != 0)
            do_read(a, nb, 1'b0, ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, nb - 1)) : -1,
                    1'b0, 0);
         else
            do_write(a, {$urandom, $urandom, $urandom, $urandom}, 1'b0, -1, 0,
                     ($urandom_range(0, 4) == 0), 0, -1);
      end

      do_write(32'h8000_0600, {$urandom, $urandom, $urandom, $urandom}, 1'b1, -1, 0, 1'b0, 0, 2);
      for (int i = 0; i < 8; i++) rd_words[i] = $urandom;
      do_read(32'h8000_0700, 4, 1'b1, -1, 1'b0, 6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
